// File: rtl/mema_loader.sv
// Streams a DIM x DIM matrix of signed elements (row-major) into memA one row at a time,
// then idles through the systolic drain window, pulsing done when the array has emptied.
// Rows are written bottom-up: the first completed row lands at memA row DIM-1.
module mema_loader #(
    parameter int BITS_AB = 8,
    parameter int DIM     = 8,
    localparam int ROWBITS = (DIM > 1) ? $clog2(DIM) : 1
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 clr,
    input  logic                                 in_valid,
    input  logic signed [BITS_AB-1:0]            in_data,
    output logic                                 in_ready,
    output logic                                 WrEn,
    output logic        [ROWBITS-1:0]            Arow,
    output logic signed [DIM-1:0][BITS_AB-1:0]   Ain,
    output logic                                 en,
    output logic                                 done
);

    // Drain window covers the time for the skewed operands to pass fully through the array.
    localparam int DRAIN_CYCLES = 3 * DIM - 2;
    localparam int DBITS        = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    localparam logic [ROWBITS-1:0] LAST_IDX   = ROWBITS'(DIM - 1);
    localparam logic [DBITS-1:0]   DRAIN_LAST = DBITS'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {
        StFill,
        StGap,
        StDrain,
        StDone
    } state_e;

    state_e                        state_q;
    logic [ROWBITS-1:0]            row_q;
    logic [ROWBITS-1:0]            col_q;
    logic [DBITS-1:0]              drain_q;
    logic [DIM-1:0][BITS_AB-1:0]   rowbuf_q;
    logic [DIM-1:0][BITS_AB-1:0]   rowbuf_d;
    logic                          wren_q;
    logic [ROWBITS-1:0]            arow_q;
    logic [DIM-1:0][BITS_AB-1:0]   ain_q;

    logic accept;
    logic row_end;
    logic last_elem;

    // Handshake decode and the row buffer including the element accepted this cycle, so a
    // completed row can be written out on the same edge that captures its last element.
    always_comb begin
        accept    = (state_q == StFill) && in_valid;
        row_end   = accept && (col_q == LAST_IDX);
        last_elem = row_end && (row_q == LAST_IDX);
        rowbuf_d  = rowbuf_q;
        if (accept) begin
            rowbuf_d[col_q] = in_data;
        end
    end

    // Loader FSM: counters, row buffer and registered memA write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StFill;
            row_q    <= '0;
            col_q    <= '0;
            drain_q  <= '0;
            rowbuf_q <= '0;
            wren_q   <= 1'b0;
            arow_q   <= '0;
            ain_q    <= '0;
        end else begin
            wren_q <= 1'b0;
            if (clr) begin
                // Abort wins over any handshake; the memA port keeps its last row.
                state_q <= StFill;
                row_q   <= '0;
                col_q   <= '0;
                drain_q <= '0;
            end else begin
                unique case (state_q)
                    StFill: begin
                        if (accept) begin
                            rowbuf_q <= rowbuf_d;
                            if (row_end) begin
                                col_q  <= '0;
                                row_q  <= row_q + ROWBITS'(1);
                                wren_q <= 1'b1;
                                arow_q <= LAST_IDX - row_q;
                                ain_q  <= rowbuf_d;
                                if (last_elem) begin
                                    state_q <= StGap;
                                end
                            end else begin
                                col_q <= col_q + ROWBITS'(1);
                            end
                        end
                    end
                    StGap: begin
                        state_q <= StDrain;
                    end
                    StDrain: begin
                        if (drain_q == DRAIN_LAST) begin
                            drain_q <= '0;
                            state_q <= StDone;
                        end else begin
                            drain_q <= drain_q + DBITS'(1);
                        end
                    end
                    StDone: begin
                        state_q <= StFill;
                        row_q   <= '0;
                        col_q   <= '0;
                        drain_q <= '0;
                    end
                    default: begin
                        state_q <= StFill;
                    end
                endcase
            end
        end
    end

    assign in_ready = (state_q == StFill);
    assign en       = (state_q == StDrain);
    assign done     = (state_q == StDone);
    assign WrEn     = wren_q;
    assign Arow     = arow_q;
    assign Ain      = ain_q;

endmodule

// File: tb/tb_mema_loader.sv
// Bench for mema_loader: a directed vector table, then randomized streams checked every cycle
// against a frame-level model (element count plus a countdown of the busy window).
module tb_mema_loader;

    localparam int BITS_AB = 8;
    localparam int DIM     = 8;
    localparam int NEL     = DIM * DIM;
    localparam int BUSY    = 3 * DIM;  // GAP + (3*DIM-2) DRAIN + DONE

    logic                              clk = 1'b0;
    logic                              rst_n = 1'b0;
    logic                              clr = 1'b0;
    logic                              in_valid = 1'b0;
    logic signed [BITS_AB-1:0]         in_data = '0;
    logic                              in_ready;
    logic                              WrEn;
    logic [2:0]                        Arow;
    logic signed [DIM-1:0][BITS_AB-1:0] Ain;
    logic                              en;
    logic                              done;

    mema_loader #(
        .BITS_AB(BITS_AB),
        .DIM    (DIM)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr),
        .in_valid(in_valid),
        .in_data (in_data),
        .in_ready(in_ready),
        .WrEn    (WrEn),
        .Arow    (Arow),
        .Ain     (Ain),
        .en      (en),
        .done    (done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    string phase = "init";

    // Frame-level model state
    int                          m_cnt;   // elements accepted in the current frame
    int                          m_wait;  // remaining cycles of the busy window, 0 = filling
    logic                        m_wren;
    logic [2:0]                  m_arow;
    logic [DIM-1:0][BITS_AB-1:0] m_ain;
    logic [BITS_AB-1:0]          m_row [DIM];

    int c_wren, c_en, c_done;
    logic [BITS_AB-1:0] frame [NEL];

    typedef struct {
        logic               c;
        logic               v;
        logic [BITS_AB-1:0] d;
        logic               e_wren;
        logic [2:0]         e_arow;
        logic [BITS_AB-1:0] e_a0;
        logic [BITS_AB-1:0] e_a7;
    } vec_t;

    vec_t tbl [20];

    task automatic model_reset();
        m_cnt  = 0;
        m_wait = 0;
        m_wren = 1'b0;
        m_arow = '0;
        m_ain  = '0;
        for (int i = 0; i < DIM; i++) m_row[i] = '0;
    endtask

    task automatic model_edge(input logic c, input logic v, input logic [BITS_AB-1:0] d);
        m_wren = 1'b0;
        if (c) begin
            m_cnt  = 0;
            m_wait = 0;
        end else if (m_wait > 0) begin
            m_wait--;
        end else if (v) begin
            m_row[m_cnt % DIM] = d;
            m_cnt++;
            if (m_cnt % DIM == 0) begin
                m_wren = 1'b1;
                m_arow = 3'(DIM - m_cnt / DIM);
                for (int i = 0; i < DIM; i++) m_ain[i] = m_row[i];
                if (m_cnt == NEL) begin
                    m_cnt  = 0;
                    m_wait = BUSY;
                end
            end
        end
    endtask

    task automatic check_model();
        logic e_rdy, e_en, e_done;
        e_rdy  = (m_wait == 0);
        e_en   = (m_wait >= 2) && (m_wait <= BUSY - 1);
        e_done = (m_wait == 1);
        n_tests++;
        if (in_ready !== e_rdy || en !== e_en || done !== e_done || WrEn !== m_wren ||
            Arow !== m_arow || Ain !== m_ain) begin
            n_fail++;
            $display("FAIL %s: got rdy=%b en=%b done=%b wren=%b arow=%0d ain=%h, want rdy=%b en=%b done=%b wren=%b arow=%0d ain=%h",
                     phase, in_ready, en, done, WrEn, Arow, Ain,
                     e_rdy, e_en, e_done, m_wren, m_arow, m_ain);
        end
        c_wren += int'(WrEn);
        c_en   += int'(en);
        c_done += int'(done);
    endtask

    task automatic cycle(input logic c, input logic v, input logic [BITS_AB-1:0] d);
        clr      = c;
        in_valid = v;
        in_data  = d;
        @(posedge clk);
        if (rst_n) model_edge(c, v, d);
        #1;
        check_model();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 8'($urandom));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        check_model();
        repeat (2) begin
            @(posedge clk);
            #1;
            check_model();
        end
        rst_n = 1'b1;
        #1;
        check_model();
    endtask

    // Feeds frame[] until stop_at elements are accepted, or until the frame completes when
    // stop_at == NEL. last_gaps forces idle cycles while the final element is pending.
    task automatic stream(input int pct, input int last_gaps, input int stop_at,
                          input int clr_pct);
        bit fin = 1'b0;
        int gaps = last_gaps;
        for (int g = 0; g < 4000 && !fin; g++) begin
            logic v, c;
            v = ($urandom_range(99) < pct);
            c = ($urandom_range(999) < clr_pct);
            if (m_cnt == NEL - 1 && gaps > 0) begin
                v = 1'b0;
                gaps--;
            end
            cycle(c, v, v ? frame[m_cnt] : 8'($urandom));
            fin = (stop_at < NEL) ? (m_cnt == stop_at && m_wait == 0) : (m_wait == BUSY);
        end
        n_tests++;
        if (!fin) begin
            n_fail++;
            $display("FAIL %s stream_timeout: got unfinished, want frame complete", phase);
        end
    endtask

    task automatic check_counts(input int ew, input int ee, input int ed);
        n_tests++;
        if (c_wren != ew || c_en != ee || c_done != ed) begin
            n_fail++;
            $display("FAIL %s counts: got wren=%0d en=%0d done=%0d, want wren=%0d en=%0d done=%0d",
                     phase, c_wren, c_en, c_done, ew, ee, ed);
        end
    endtask

    task automatic clear_counts();
        c_wren = 0;
        c_en   = 0;
        c_done = 0;
    endtask

    task automatic fill_ramp();
        for (int i = 0; i < NEL; i++) frame[i] = 8'(i);
    endtask

    task automatic fill_random();
        for (int i = 0; i < NEL; i++) frame[i] = 8'($urandom);
        frame[$urandom_range(NEL - 1)] = 8'h80;
        frame[$urandom_range(NEL - 1)] = 8'h7f;
    endtask

    function automatic vec_t mk(input logic c, input logic v, input logic [7:0] d,
                                input logic w, input logic [2:0] a, input logic [7:0] a0,
                                input logic [7:0] a7);
        vec_t r;
        r.c = c; r.v = v; r.d = d; r.e_wren = w; r.e_arow = a; r.e_a0 = a0; r.e_a7 = a7;
        return r;
    endfunction

    initial begin
        clear_counts();
        model_reset();

        // Directed table: first row with a valid gap, clr overriding a handshake, then a row
        // carrying the signed extremes that must land at Arow 7 again.
        tbl[0] = mk(0, 1, 8'd10, 0, 3'd0, 8'h00, 8'h00);
        tbl[1] = mk(0, 0, 8'd99, 0, 3'd0, 8'h00, 8'h00);
        for (int i = 2; i < 8; i++) tbl[i] = mk(0, 1, 8'(9 + i), 0, 3'd0, 8'h00, 8'h00);
        tbl[8]  = mk(0, 1, 8'd17, 1, 3'd7, 8'd10, 8'd17);
        tbl[9]  = mk(0, 0, 8'd0,  0, 3'd7, 8'd10, 8'd17);
        tbl[10] = mk(1, 1, 8'd55, 0, 3'd7, 8'd10, 8'd17);
        tbl[11] = mk(0, 1, 8'h80, 0, 3'd7, 8'd10, 8'd17);
        for (int i = 12; i < 18; i++) tbl[i] = mk(0, 1, 8'(i - 11), 0, 3'd7, 8'd10, 8'd17);
        tbl[18] = mk(0, 1, 8'h7f, 1, 3'd7, 8'h80, 8'h7f);
        tbl[19] = mk(0, 1, 8'd20, 0, 3'd7, 8'h80, 8'h7f);

        phase = "reset";
        do_reset();

        for (int i = 0; i < 20; i++) begin
            clr      = tbl[i].c;
            in_valid = tbl[i].v;
            in_data  = tbl[i].d;
            @(posedge clk);
            #1;
            n_tests++;
            if (WrEn !== tbl[i].e_wren || Arow !== tbl[i].e_arow || Ain[0] !== tbl[i].e_a0 ||
                Ain[7] !== tbl[i].e_a7 || in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL vec%0d: got wren=%b arow=%0d a0=%h a7=%h rdy=%b, want wren=%b arow=%0d a0=%h a7=%h rdy=1",
                         i, WrEn, Arow, Ain[0], Ain[7], in_ready,
                         tbl[i].e_wren, tbl[i].e_arow, tbl[i].e_a0, tbl[i].e_a7);
            end
        end

        // Full ramp frame, valid held high
        phase = "ramp";
        do_reset();
        cycle(1'b1, 1'b1, 8'd5);  // clr at row=col=0 is harmless and blocks the handshake
        fill_ramp();
        clear_counts();
        stream(100, 0, NEL, 0);
        idle(BUSY + 4);
        check_counts(DIM, 3 * DIM - 2, 1);

        // Random valid gaps, including stalls on the final column
        phase = "gaps";
        clear_counts();
        stream(55, 3, NEL, 0);
        idle(BUSY + 2);
        check_counts(DIM, 3 * DIM - 2, 1);

        // Abort after 20 elements, then a fresh random frame
        phase = "clr";
        fill_ramp();
        stream(70, 0, 20, 0);
        cycle(1'b1, 1'b1, 8'($urandom));
        fill_random();
        clear_counts();
        stream(80, 1, NEL, 0);
        idle(BUSY + 2);
        check_counts(DIM, 3 * DIM - 2, 1);

        // Reset during drain cycle 10, then full reload
        phase = "rst_drain";
        fill_ramp();
        stream(100, 0, NEL, 0);
        idle(10);
        do_reset();
        clear_counts();
        stream(100, 0, NEL, 0);
        idle(BUSY + 2);
        check_counts(DIM, 3 * DIM - 2, 1);

        // Random signed frames with random throttling and sporadic aborts
        phase = "random";
        for (int f = 0; f < 6; f++) begin
            fill_random();
            stream($urandom_range(30, 100), $urandom_range(0, 2), NEL, 3);
            idle($urandom_range(0, BUSY + 3));
        end
        idle(BUSY + 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mema_loader.md
MEMA_LOADER -- requirements
Module: mema_loader

Interface
REQ-001 SHALL have parameter BITS_AB, default 8, signed element width.
REQ-002 SHALL have parameter DIM, default 8, matrix dimension; ROWBITS = $clog2(DIM).
REQ-003 SHALL have one clock and an asynchronous, active-low reset: clk  input  1  rising-edge clock.
REQ-004 SHALL have: rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have: clr  input  1  synchronous abort, returns to FILL.
REQ-006 SHALL have: in_valid  input  1  element stream valid.
REQ-007 SHALL have: in_data  input  signed [BITS_AB-1:0]  matrix element, row-major order.
REQ-008 SHALL have: in_ready  output  1  loader accepts an element.
REQ-009 SHALL have: WrEn  output  1  memA row write strobe.
REQ-010 SHALL have: Arow  output  [ROWBITS-1:0]  memA row select.
REQ-011 SHALL have: Ain  output  signed [BITS_AB-1:0] [DIM-1:0]  memA row data.
REQ-012 SHALL have: en  output  1  memA shift enable.
REQ-013 SHALL have: done  output  1  one-cycle completion pulse.

Function
REQ-014 SHALL implement states FILL, GAP, DRAIN, DONE; in_ready = (state==FILL), en = (state==DRAIN), done = (state==DONE), all decoded directly from state.
REQ-015 Handshake SHALL occur when in_valid && in_ready; in_data is ignored otherwise, and the counters hold while in_valid is low.
REQ-016 Each accepted element SHALL be stored in row buffer slot col, with col counting 0..DIM-1 and wrapping to 0.
REQ-017 On acceptance with col==DIM-1, the next edge SHALL register WrEn=1, Arow=DIM-1-row, Ain = full row including the last element, and SHALL increment row.
REQ-018 WrEn SHALL be high for exactly one cycle per completed row; Ain and Arow SHALL hold their values between writes.
REQ-019 Acceptance SHALL continue in the WrEn cycle with no bubble while in FILL.
REQ-020 Acceptance of element (DIM-1, DIM-1) SHALL move the state FILL->GAP; that last WrEn appears in the GAP cycle, with en=0.
REQ-021 GAP SHALL last one cycle and then move to DRAIN.
REQ-022 DRAIN SHALL last exactly 3*DIM-2 cycles, counted by a drain counter, and then move to DONE.
REQ-023 DONE SHALL last one cycle, move to FILL, and clear row, col and the drain counter.
REQ-024 Total latency SHALL be: last accept at cycle T -> WrEn at T+1 -> en high over T+2..T+3*DIM-1 -> done at T+3*DIM.
REQ-025 clr SHALL override any handshake in the same cycle: next state FILL, counters 0, WrEn=0, Ain and Arow held.
REQ-026 clr SHALL have no effect while in FILL with row=col=0.

Reset
REQ-027 Asserting rst_n low SHALL force state=FILL, row=col=drain counter=0, WrEn=0, Arow=0, all Ain lanes 0, and row buffer 0.
REQ-028 During and after reset, in_ready SHALL be 1 and en and done SHALL be 0.
REQ-029 Reset asserted mid-FILL or mid-DRAIN SHALL abort immediately with no further WrEn or en.

Verification
REQ-030 Reset, then stream 64 elements A[r][c]=r*8+c with in_valid held high -> 8 WrEn pulses on consecutive row-completion cycles, Arow 7,6,...,0, pulse k carrying Ain[c]=k*8+c.
REQ-031 Same stream followed by idle -> GAP cycle with en=0, en high for exactly 22 cycles, done for 1 cycle, then in_ready=1.
REQ-032 Random in_valid gaps, including one in the last column -> identical Arow/Ain sequence to REQ-030; row and col hold during gaps.
REQ-033 clr after 20 accepted elements, then a fresh 64-element stream -> first WrEn has Arow=7 and carries the new row 0; no stale data appears.
REQ-034 rst_n low during DRAIN cycle 10 -> en=0 at once; after release, in_ready=1 and a full reload reproduces REQ-030/031.
REQ-035 Loader wired to memA with random signed elements (including -128 and 127) -> the skewed memA output over the 22 en cycles matches the reference skew model with zero errors.
